spinn_aer_if_ctrl_regs: RTL
===========================

SPINN_AER_IF_CTRL_REGS -- requirements
Module: spinn_aer_if_ctrl_regs

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter NUM_CH SHALL be provided, default 2: number of independent output channels, range 1..16.
REQ-003 Parameter MODE_BITS SHALL be provided, default 3: width of each channel's mode field.
REQ-004 Parameter VKEY_BITS SHALL be provided, default 16: width of each channel's virtual key.
REQ-005 Parameter CTRL_KEY SHALL be provided, default 16'hFFFE: control-packet match value for key[31:16].
REQ-006 Parameters INIT_GO (default 0), INIT_MODE (default 0) and INIT_VKEY (default 16'h0200) SHALL be provided as the reset values for every channel.
REQ-007 Port clk SHALL be an input, 1 bit: system clock.
REQ-008 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-009 Port cpkt_data SHALL be an input, 72 bits: incoming SpiNNaker packet.
REQ-010 Port cpkt_vld SHALL be an input, 1 bit, and port cpkt_rdy SHALL be an output, 1 bit: the incoming-packet handshake.
REQ-011 Port rpkt_data SHALL be an output, 72 bits: reply packet.
REQ-012 Port rpkt_vld SHALL be an output, 1 bit, and port rpkt_rdy SHALL be an input, 1 bit: the reply handshake.
REQ-013 Port go SHALL be an output, NUM_CH bits: per-channel enable.
REQ-014 Port vmode SHALL be an output, NUM_CH*MODE_BITS bits: per-channel mode, with channel i at bits [i*MODE_BITS +: MODE_BITS].
REQ-015 Port vkey SHALL be an output, NUM_CH*VKEY_BITS bits: per-channel virtual key, packed the same way as vmode.
REQ-016 Port err_cnt SHALL be an output, 8 bits: count of rejected control packets.

Function
REQ-017 Packet fields SHALL be: key = data[39:8], payload = data[71:40], payload-present flag = data[1], opcode = key[11:8], channel = key[7:0].
REQ-018 A packet SHALL be accepted on any cycle where cpkt_vld and cpkt_rdy are both high.
REQ-019 cpkt_rdy SHALL be high only in state IDLE.
REQ-020 An accepted packet with key[31:16] != CTRL_KEY SHALL be consumed silently, with no state or counter change.
REQ-021 A matched packet SHALL be rejected, incrementing err_cnt, when any of the following holds: channel >= NUM_CH; opcode > 3; opcode 0..2 with the payload-present flag clear.
REQ-022 Opcode 0 (SET_GO) SHALL load go[ch] from payload[0].
REQ-023 Opcode 1 (SET_MODE) SHALL load the selected vmode field from payload[MODE_BITS-1:0].
REQ-024 Opcode 2 (SET_VKEY) SHALL load the selected vkey field from payload[VKEY_BITS-1:0].
REQ-025 Every register write SHALL be visible on the outputs in the cycle after acceptance.
REQ-026 Opcode 3 (READ) SHALL move the state machine IDLE->REPLY and assert rpkt_vld in the cycle after acceptance.
REQ-027 The READ reply SHALL carry: key = request key; payload = {go[ch], vmode[ch], vkey[ch]} zero-extended to 32 bits, with vkey in the LSBs; data[1] = 1; data[7:2] = 0; data[0] set so that the 72-bit packet has odd parity.
REQ-028 rpkt_data SHALL be held stable while rpkt_vld is high and rpkt_rdy is low.
REQ-029 On rpkt_vld and rpkt_rdy both high the state SHALL go REPLY->IDLE and rpkt_vld SHALL deassert in the next cycle.
REQ-030 A READ issued in the cycle after a write to the same channel SHALL return the new value.
REQ-031 err_cnt SHALL saturate at 8'hFF.
REQ-032 A READ with an invalid channel SHALL be rejected per REQ-021 and SHALL produce no reply.

Reset
REQ-033 On rst the block SHALL set: go = INIT_GO on every channel; vmode = INIT_MODE on every channel; vkey = INIT_VKEY on every channel; err_cnt = 0; state = IDLE; rpkt_vld = 0.
REQ-034 A reset asserted while in REPLY SHALL discard the pending reply without emitting it.
REQ-035 cpkt_rdy SHALL be high in the first cycle after rst deasserts.

Structure
REQ-036 The shared header SHALL hold PKT_BITS, the field-position constants, the opcode values and CTRL_KEY.
REQ-037 Odd-parity generation SHALL be implemented in one sub-module, spio_pkt_parity_gen, so that other packet sources can reuse it.

Verification
REQ-038 The bench SHALL cover reset then idle: go = 0, vkey[15:0] = 16'h0200, cpkt_rdy = 1, rpkt_vld = 0.
REQ-039 The bench SHALL cover SET_GO: key 32'hFFFE0001 with payload 1 -> go = 2'b10 one cycle after acceptance.
REQ-040 The bench SHALL cover SET_VKEY then READ on channel 1: payload 16'h1234, with rpkt_rdy held low for 3 cycles -> rpkt_data stable throughout, payload LSBs 16'h1234, odd parity; cpkt_rdy = 0 until the reply handshake completes.
REQ-041 The bench SHALL cover errors: channel 5, opcode 7, and SET_MODE with no payload -> err_cnt = 3 and no output change; 300 bad packets -> err_cnt = 8'hFF.
REQ-042 The bench SHALL cover a foreign key: key 32'h12340001 -> packet consumed, no output or err_cnt change.
REQ-043 The bench SHALL cover rst asserted during REPLY -> rpkt_vld = 0 in the next cycle and cpkt_rdy = 1 after reset.

Source files
------------

// File: rtl/spinn_aer_if_ctrl_regs_pkg.sv
// Shared packet layout, opcodes and control-key match value for the AER
// interface control-register block.
package spinn_aer_if_ctrl_regs_pkg;

   localparam int PKT_BITS   = 72;

   // fields within the 72-bit packet
   localparam int PAR_BIT    = 0;
   localparam int PLF_BIT    = 1;
   localparam int KEY_LSB    = 8;
   localparam int KEY_BITS   = 32;
   localparam int PL_LSB     = 40;
   localparam int PL_BITS    = 32;

   // fields within the 32-bit key
   localparam int CH_LSB     = 0;
   localparam int CH_BITS    = 8;
   localparam int OPC_LSB    = 8;
   localparam int OPC_BITS   = 4;
   localparam int MATCH_LSB  = 16;
   localparam int MATCH_BITS = 16;

   localparam logic [OPC_BITS-1:0] OPC_SET_GO   = 4'd0;
   localparam logic [OPC_BITS-1:0] OPC_SET_MODE = 4'd1;
   localparam logic [OPC_BITS-1:0] OPC_SET_VKEY = 4'd2;
   localparam logic [OPC_BITS-1:0] OPC_READ     = 4'd3;

   localparam logic [MATCH_BITS-1:0] CTRL_KEY = 16'hFFFE;

   // decoded view of an incoming packet
   typedef struct packed {
      logic [PL_BITS-1:0]  payload;
      logic [KEY_BITS-1:0] key;
      logic                has_pl;
   } pkt_fields_t;

endpackage

// File: rtl/spinn_aer_if_ctrl_regs_parity.sv
// Odd-parity generator for SpiNNaker packets: fills bit 0 so the whole
// 72-bit packet carries an odd number of ones. Reusable by any packet source.
module spio_pkt_parity_gen
   import spinn_aer_if_ctrl_regs_pkg::*;
(
   input  logic [PKT_BITS-1:1] body,
   output logic [PKT_BITS-1:0] pkt
);

   // parity bit is the complement of the body's XOR reduction
   always_comb begin
      pkt = {body, ~(^body)};
   end

endmodule

// File: rtl/spinn_aer_if_ctrl_regs.sv
// Per-channel go/mode/virtual-key registers written and read through
// SpiNNaker control packets; READ requests return a parity-protected reply.
module spinn_aer_if_ctrl_regs
   import spinn_aer_if_ctrl_regs_pkg::*;
#(
   parameter int                    NUM_CH    = 2,
   parameter int                    MODE_BITS = 3,
   parameter int                    VKEY_BITS = 16,
   parameter logic [15:0]           CTRL_KEY  = spinn_aer_if_ctrl_regs_pkg::CTRL_KEY,
   parameter logic                  INIT_GO   = 1'b0,
   parameter logic [MODE_BITS-1:0]  INIT_MODE = '0,
   parameter logic [VKEY_BITS-1:0]  INIT_VKEY = VKEY_BITS'(16'h0200)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PKT_BITS-1:0]           cpkt_data,
   input  logic                          cpkt_vld,
   output logic                          cpkt_rdy,
   output logic [PKT_BITS-1:0]           rpkt_data,
   output logic                          rpkt_vld,
   input  logic                          rpkt_rdy,
   output logic [NUM_CH-1:0]             go,
   output logic [NUM_CH*MODE_BITS-1:0]   vmode,
   output logic [NUM_CH*VKEY_BITS-1:0]   vkey,
   output logic [7:0]                    err_cnt
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_REPLY = 1'b1;

   logic [0:0]                 state_q, state_d;
   logic [NUM_CH-1:0]          go_q, go_d;
   logic [NUM_CH*MODE_BITS-1:0] vmode_q, vmode_d;
   logic [NUM_CH*VKEY_BITS-1:0] vkey_q, vkey_d;
   logic [7:0]                 err_cnt_q, err_cnt_d;
   logic [PKT_BITS-1:0]        rpkt_data_q, rpkt_data_d;

   pkt_fields_t                f;
   logic [CH_BITS-1:0]         ch;
   logic [OPC_BITS-1:0]        opc;
   logic                       accept, match, ch_ok, opc_ok, pl_ok, valid;
   logic                       sel_go;
   logic [MODE_BITS-1:0]       sel_mode;
   logic [VKEY_BITS-1:0]       sel_vkey;
   logic [PL_BITS-1:0]         rd_pl;
   logic [PKT_BITS-1:0]        reply;
   logic                       unused_bits;

   assign f.payload = cpkt_data[PL_LSB +: PL_BITS];
   assign f.key     = cpkt_data[KEY_LSB +: KEY_BITS];
   assign f.has_pl  = cpkt_data[PLF_BIT];
   assign ch        = f.key[CH_LSB +: CH_BITS];
   assign opc       = f.key[OPC_LSB +: OPC_BITS];
   assign unused_bits = ^cpkt_data;

   // decode the incoming packet and classify it
   always_comb begin
      accept = cpkt_vld && (state_q == ST_IDLE);
      match  = (f.key[MATCH_LSB +: MATCH_BITS] == CTRL_KEY);
      ch_ok  = (int'(ch) < NUM_CH);
      opc_ok = (opc <= OPC_READ);
      pl_ok  = f.has_pl || (opc == OPC_READ);
      valid  = ch_ok && opc_ok && pl_ok;
   end

   // pick the addressed channel's current registers for READ replies
   always_comb begin
      sel_go   = 1'b0;
      sel_mode = '0;
      sel_vkey = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(ch) == i) begin
            sel_go   = go_q[i];
            sel_mode = vmode_q[i*MODE_BITS +: MODE_BITS];
            sel_vkey = vkey_q[i*VKEY_BITS +: VKEY_BITS];
         end
      end
      rd_pl = '0;
      rd_pl[VKEY_BITS-1:0]               = sel_vkey;
      rd_pl[VKEY_BITS +: MODE_BITS]      = sel_mode;
      rd_pl[VKEY_BITS+MODE_BITS]         = sel_go;
   end

   spio_pkt_parity_gen u_par (
      .body ({rd_pl, f.key, 6'b0, 1'b1}),
      .pkt  (reply)
   );

   // register writes, error counting and the IDLE/REPLY sequencing
   always_comb begin
      state_d     = state_q;
      go_d        = go_q;
      vmode_d     = vmode_q;
      vkey_d      = vkey_q;
      err_cnt_d   = err_cnt_q;
      rpkt_data_d = rpkt_data_q;
      if (state_q == ST_REPLY) begin
         if (rpkt_rdy) state_d = ST_IDLE;
      end else if (accept && match) begin
         if (!valid) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end else if (opc == OPC_READ) begin
            rpkt_data_d = reply;
            state_d     = ST_REPLY;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (int'(ch) == i) begin
                  case (opc)
                     OPC_SET_GO:   go_d[i] = f.payload[0];
                     OPC_SET_MODE: vmode_d[i*MODE_BITS +: MODE_BITS] = f.payload[MODE_BITS-1:0];
                     default:      vkey_d[i*VKEY_BITS +: VKEY_BITS] = f.payload[VKEY_BITS-1:0];
                  endcase
               end
            end
         end
      end
   end

   // state flops; reset drops any pending reply
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         go_q        <= {NUM_CH{INIT_GO}};
         vmode_q     <= {NUM_CH{INIT_MODE}};
         vkey_q      <= {NUM_CH{INIT_VKEY}};
         err_cnt_q   <= 8'h00;
         rpkt_data_q <= '0;
      end else begin
         state_q     <= state_d;
         go_q        <= go_d;
         vmode_q     <= vmode_d;
         vkey_q      <= vkey_d;
         err_cnt_q   <= err_cnt_d;
         rpkt_data_q <= rpkt_data_d;
      end
   end

   assign cpkt_rdy  = (state_q == ST_IDLE);
   assign rpkt_vld  = (state_q == ST_REPLY);
   assign rpkt_data = rpkt_data_q;
   assign go        = go_q;
   assign vmode     = vmode_q;
   assign vkey      = vkey_q;
   assign err_cnt   = err_cnt_q;

endmodule
